// File: rtl/leaf_stream_bridge_if.sv
// Bundle of all leaf-side and user-side stream lanes plus status for the bridge.
// The bridge takes the slave view; the environment driving it takes the master view.
interface leaf_stream_bridge_if #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int CNT_BITS      = 16
);
  logic                                          flush;
  // inbound: leaf interface -> bridge -> user operator
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]          din_interface2bridge;
  logic [NUM_IN_PORTS-1:0]                       vld_interface2bridge;
  logic [NUM_IN_PORTS-1:0]                       ack_bridge2interface;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]          dout_bridge2user;
  logic [NUM_IN_PORTS-1:0]                       vld_bridge2user;
  logic [NUM_IN_PORTS-1:0]                       ack_user2bridge;
  // outbound: user operator -> bridge -> leaf interface
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]         din_user2bridge;
  logic [NUM_OUT_PORTS-1:0]                      vld_user2bridge;
  logic [NUM_OUT_PORTS-1:0]                      ack_bridge2user;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]         dout_bridge2interface;
  logic [NUM_OUT_PORTS-1:0]                      vld_bridge2interface;
  logic [NUM_OUT_PORTS-1:0]                      ack_interface2bridge;
  // status, inbound lanes in the low positions
  logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]         full_status;
  logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS-1:0] xfer_cnt;

  modport slave (
    input  flush,
    input  din_interface2bridge, vld_interface2bridge, ack_user2bridge,
    input  din_user2bridge, vld_user2bridge, ack_interface2bridge,
    output ack_bridge2interface, dout_bridge2user, vld_bridge2user,
    output ack_bridge2user, dout_bridge2interface, vld_bridge2interface,
    output full_status, xfer_cnt
  );

  modport master (
    output flush,
    output din_interface2bridge, vld_interface2bridge, ack_user2bridge,
    output din_user2bridge, vld_user2bridge, ack_interface2bridge,
    input  ack_bridge2interface, dout_bridge2user, vld_bridge2user,
    input  ack_bridge2user, dout_bridge2interface, vld_bridge2interface,
    input  full_status, xfer_cnt
  );
endinterface

// File: rtl/leaf_stream_bridge.sv
// Leaf stream bridge: one independent first-word-fall-through FIFO per lane,
// inbound lanes (leaf -> user) first, outbound lanes (user -> leaf) after them.
// Each lane keeps a saturating count of words popped towards its consumer.
module leaf_stream_bridge #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int DEPTH_BITS    = 3,
  parameter int CNT_BITS      = 16
) (
  input  logic                 clk_user,
  input  logic                 reset,
  leaf_stream_bridge_if.slave  bus
);

  localparam int NUM_LANES = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int DEPTH     = 1 << DEPTH_BITS;

  localparam logic [DEPTH_BITS:0]     FULL_COUNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]     ZERO_COUNT = (DEPTH_BITS+1)'(0);
  localparam logic [DEPTH_BITS:0]     ONE_COUNT  = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0]   ZERO_PTR   = DEPTH_BITS'(0);
  localparam logic [DEPTH_BITS-1:0]   ONE_PTR    = DEPTH_BITS'(1);
  localparam logic [CNT_BITS-1:0]     ZERO_XFER  = CNT_BITS'(0);
  localparam logic [CNT_BITS-1:0]     ONE_XFER   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0]     MAX_XFER   = {CNT_BITS{1'b1}};
  localparam logic [PAYLOAD_BITS-1:0] ZERO_WORD  = {PAYLOAD_BITS{1'b0}};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr_r;
    logic [DEPTH_BITS-1:0]   rd_ptr_r;
    logic [DEPTH_BITS-1:0]   rd_ptr_nxt_s;
    logic [DEPTH_BITS:0]     count_r;
    logic [DEPTH_BITS:0]     count_nxt_s;
    logic [PAYLOAD_BITS-1:0] dout_r;
    logic [PAYLOAD_BITS-1:0] head_nxt_s;
    logic [PAYLOAD_BITS-1:0] push_data_s;
    logic [CNT_BITS-1:0]     xfer_r;
    logic                    push_vld_s;
    logic                    pop_ack_s;
    logic                    push_ack_s;
    logic                    pop_vld_s;
    logic                    push_s;
    logic                    pop_s;

    // Handshake flags come from the registered count only, so no vld->ack path exists.
    assign push_ack_s = (count_r != FULL_COUNT) && !bus.flush && !reset;
    assign pop_vld_s  = (count_r != ZERO_COUNT) && !reset;

    // Route this lane onto the inbound or outbound side of the bundle.
    if (l < NUM_IN_PORTS) begin : g_in
      assign push_data_s = bus.din_interface2bridge[l*PAYLOAD_BITS +: PAYLOAD_BITS];
      assign push_vld_s  = bus.vld_interface2bridge[l];
      assign pop_ack_s   = bus.ack_user2bridge[l];
      assign bus.ack_bridge2interface[l]                          = push_ack_s;
      assign bus.vld_bridge2user[l]                               = pop_vld_s;
      assign bus.dout_bridge2user[l*PAYLOAD_BITS +: PAYLOAD_BITS] = dout_r;
    end else begin : g_out
      localparam int J = l - NUM_IN_PORTS;
      assign push_data_s = bus.din_user2bridge[J*PAYLOAD_BITS +: PAYLOAD_BITS];
      assign push_vld_s  = bus.vld_user2bridge[J];
      assign pop_ack_s   = bus.ack_interface2bridge[J];
      assign bus.ack_bridge2user[J]                                    = push_ack_s;
      assign bus.vld_bridge2interface[J]                               = pop_vld_s;
      assign bus.dout_bridge2interface[J*PAYLOAD_BITS +: PAYLOAD_BITS] = dout_r;
    end

    assign bus.full_status[l]                    = (count_r == FULL_COUNT) && !reset;
    assign bus.xfer_cnt[l*CNT_BITS +: CNT_BITS]  = xfer_r;

    // Transfer decode, next occupancy and the word that will sit at the head after this edge.
    always_comb begin
      push_s       = push_vld_s && push_ack_s;
      pop_s        = pop_vld_s && pop_ack_s && !bus.flush;
      rd_ptr_nxt_s = pop_s ? (rd_ptr_r + ONE_PTR) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + ONE_COUNT;
        2'b01:   count_nxt_s = count_r - ONE_COUNT;
        default: count_nxt_s = count_r;
      endcase
      // The slot being written this edge is the new head when the FIFO was empty
      // (or drains to the incoming word), so take the incoming word directly.
      head_nxt_s = (push_s && (wr_ptr_r == rd_ptr_nxt_s)) ? push_data_s
                                                           : mem_r[rd_ptr_nxt_s];
    end

    // Lane state: reset clears everything, flush clears occupancy but keeps counters and dout.
    always_ff @(posedge clk_user) begin
      if (reset) begin
        wr_ptr_r <= ZERO_PTR;
        rd_ptr_r <= ZERO_PTR;
        count_r  <= ZERO_COUNT;
        dout_r   <= ZERO_WORD;
        xfer_r   <= ZERO_XFER;
      end else if (bus.flush) begin
        wr_ptr_r <= ZERO_PTR;
        rd_ptr_r <= ZERO_PTR;
        count_r  <= ZERO_COUNT;
      end else begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= push_data_s;
          wr_ptr_r        <= wr_ptr_r + ONE_PTR;
        end
        rd_ptr_r <= rd_ptr_nxt_s;
        count_r  <= count_nxt_s;
        // Registered head word; holds the last value once the lane runs empty.
        if (count_nxt_s != ZERO_COUNT) begin
          dout_r <= head_nxt_s;
        end
        if (pop_s && (xfer_r != MAX_XFER)) begin
          xfer_r <= xfer_r + ONE_XFER;
        end
      end
    end
  end

endmodule
